// File: rtl/ifetch_predecode_if.sv
// Shared addressing-mode type plus the bundle of bus and handshake signals
// between the fetch/pre-decode stage and its neighbours (memory bus, execute
// sequencer and PC redirect).

package typepkg;

    typedef enum logic [3:0] {
        Imp, Imm, Zp, ZpX, ZpY, IzX, IzY, Abs, AbX, AbY, Ind, Rel
    } addressing_t;

endpackage

interface ifetch_predecode_if;
    import typepkg::*;

    logic        pc_load;
    logic [15:0] pc_in;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_rdy;
    logic [7:0]  mem_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [7:0]  ins_opcode;
    addressing_t ins_mode;
    logic [15:0] ins_operand;
    logic [1:0]  ins_len;
    logic [15:0] ins_pc;
    logic [15:0] pc_next;

    // The fetch stage itself
    modport master (
        input  pc_load, pc_in, mem_rdy, mem_data, ins_ready,
        output mem_addr, mem_rd, ins_valid, ins_opcode, ins_mode,
               ins_operand, ins_len, ins_pc, pc_next
    );

    // Everything around the fetch stage (memory, sequencer)
    modport slave (
        output pc_load, pc_in, mem_rdy, mem_data, ins_ready,
        input  mem_addr, mem_rd, ins_valid, ins_opcode, ins_mode,
               ins_operand, ins_len, ins_pc, pc_next
    );

endinterface

// File: rtl/ifetch_predecode.sv
// Instruction fetch and pre-decode stage. Reads an opcode byte plus up to two
// operand bytes over the 8-bit memory bus, classifies the addressing mode and
// presents one complete instruction at a time to the execute sequencer.

module ifetch_predecode
    import typepkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    ifetch_predecode_if.master    bus
);

    typedef enum logic [1:0] {
        OP,
        LO,
        HI,
        OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [7:0]  opcode_q;
    addressing_t mode_q;
    logic [15:0] operand_q;
    logic [15:0] ins_pc_q;
    logic        rd_done;
    addressing_t dec_mode;
    logic [1:0]  dec_len;
    logic [1:0]  cur_len;

    // Opcode-to-addressing-mode classification from the column (c) and row (m) fields
    function automatic addressing_t decode_mode(input logic [7:0] op);
        logic [1:0] c;
        logic [2:0] m;
        addressing_t r;
        c = op[1:0];
        m = op[4:2];
        r = Imp;
        case (c)
            2'b01, 2'b11: begin
                case (m)
                    3'd0: r = IzX;
                    3'd1: r = Zp;
                    3'd2: r = Imm;
                    3'd3: r = Abs;
                    3'd4: r = IzY;
                    3'd5: r = ZpX;
                    3'd6: r = AbY;
                    default: r = AbX;
                endcase
                if (op == 8'h97 || op == 8'hB7) r = ZpY;
                if (op == 8'h9F || op == 8'hBF) r = AbY;
            end
            2'b00: begin
                case (m)
                    3'd0: r = op[7] ? Imm : ((op == 8'h20) ? Abs : Imp);
                    3'd1: r = Zp;
                    3'd2: r = Imp;
                    3'd3: r = (op == 8'h6C) ? Ind : Abs;
                    3'd4: r = Rel;
                    3'd5: r = ZpX;
                    3'd6: r = Imp;
                    default: r = AbX;
                endcase
            end
            default: begin
                case (m)
                    3'd0: r = op[7] ? Imm : Imp;
                    3'd1: r = Zp;
                    3'd2: r = Imp;
                    3'd3: r = Abs;
                    3'd4: r = Imp;
                    3'd5: r = (op == 8'h96 || op == 8'hB6) ? ZpY : ZpX;
                    3'd6: r = Imp;
                    default: r = (op == 8'h9E || op == 8'hBE) ? AbY : AbX;
                endcase
            end
        endcase
        return r;
    endfunction

    // Instruction length in bytes implied by an addressing mode
    function automatic logic [1:0] mode_len(input addressing_t md);
        logic [1:0] l;
        case (md)
            Imp:                  l = 2'd1;
            Abs, AbX, AbY, Ind:   l = 2'd3;
            default:              l = 2'd2;
        endcase
        return l;
    endfunction

    assign rd_done  = bus.mem_rd & bus.mem_rdy;
    assign dec_mode = decode_mode(bus.mem_data);
    assign dec_len  = mode_len(dec_mode);
    assign cur_len  = mode_len(mode_q);

    assign bus.mem_addr    = pc;
    assign bus.mem_rd      = !reset && (state != OUT);
    assign bus.pc_next     = pc;
    assign bus.ins_valid   = (state == OUT);
    assign bus.ins_opcode  = opcode_q;
    assign bus.ins_mode    = mode_q;
    assign bus.ins_operand = operand_q;
    assign bus.ins_len     = cur_len;
    assign bus.ins_pc      = ins_pc_q;

    // State register; redirects and reset both restart at the opcode fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: advance one byte per completed read, leave OUT on handshake
    always_comb begin
        state_next = state;
        if (bus.pc_load) begin
            state_next = OP;
        end else begin
            case (state)
                OP:  if (rd_done) state_next = (dec_len >= 2'd2) ? LO : OUT;
                LO:  if (rd_done) state_next = (cur_len == 2'd3) ? HI : OUT;
                HI:  if (rd_done) state_next = OUT;
                OUT: if (bus.ins_ready) state_next = OP;
                default: state_next = OP;
            endcase
        end
    end

    // Fetch PC and instruction fields; a redirect drops any read completing with it
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            opcode_q  <= 8'h00;
            mode_q    <= Imp;
            operand_q <= 16'h0000;
            ins_pc_q  <= 16'h0000;
        end else if (bus.pc_load) begin
            pc <= bus.pc_in;
        end else if (rd_done) begin
            pc <= pc + 16'd1;
            case (state)
                OP: begin
                    opcode_q  <= bus.mem_data;
                    mode_q    <= dec_mode;
                    operand_q <= 16'h0000;
                    ins_pc_q  <= pc;
                end
                LO:      operand_q <= {8'h00, bus.mem_data};
                HI:      operand_q[15:8] <= bus.mem_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_predecode.sv
// Directed bench for ifetch_predecode: a byte-array memory answers the bus and
// each task checks one scenario against hand-computed values.

module tb_ifetch_predecode;
    import typepkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mem [0:65535];

    ifetch_predecode_if bus ();

    ifetch_predecode #(.RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_data = mem[bus.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] a);
        bus.pc_load = 1'b1;
        bus.pc_in   = a;
        tick();
        bus.pc_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pc_load = 1'b0; bus.pc_in = 16'h0000;
        bus.mem_rdy = 1'b1; bus.ins_ready = 1'b0;
        tick(); tick();
        tests++; if (bus.ins_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.ins_valid); end
        tests++; if (bus.mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL rst_mem_rd: got %b expected 0", bus.mem_rd); end
        tests++; if (bus.pc_next !== 16'h0000) begin fails++; $display("[TB] FAIL rst_pc: got %h expected 0000", bus.pc_next); end
        tests++; if (bus.ins_opcode !== 8'h00) begin fails++; $display("[TB] FAIL rst_opcode: got %h expected 00", bus.ins_opcode); end
        tests++; if (bus.ins_mode !== Imp) begin fails++; $display("[TB] FAIL rst_mode: got %0d expected %0d", bus.ins_mode, Imp); end
        tests++; if (bus.ins_len !== 2'd1 || bus.ins_operand !== 16'h0000 || bus.ins_pc !== 16'h0000) begin
            fails++; $display("[TB] FAIL rst_fields: got len %0d op %h pc %h expected 1 0000 0000", bus.ins_len, bus.ins_operand, bus.ins_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_imm();
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        load_pc(16'h8000);
        tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8000) begin fails++; $display("[TB] FAIL imm_rd0: got rd %b addr %h expected 1 8000", bus.mem_rd, bus.mem_addr); end
        tick();
        tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8001) begin fails++; $display("[TB] FAIL imm_rd1: got rd %b addr %h expected 1 8001", bus.mem_rd, bus.mem_addr); end
        tick();
        tests++; if (bus.ins_valid !== 1'b1) begin fails++; $display("[TB] FAIL imm_valid: got %b expected 1", bus.ins_valid); end
        tests++; if (bus.ins_opcode !== 8'hA9) begin fails++; $display("[TB] FAIL imm_opcode: got %h expected A9", bus.ins_opcode); end
        tests++; if (bus.ins_mode !== Imm) begin fails++; $display("[TB] FAIL imm_mode: got %0d expected %0d", bus.ins_mode, Imm); end
        tests++; if (bus.ins_operand !== 16'h0042) begin fails++; $display("[TB] FAIL imm_operand: got %h expected 0042", bus.ins_operand); end
        tests++; if (bus.ins_len !== 2'd2) begin fails++; $display("[TB] FAIL imm_len: got %0d expected 2", bus.ins_len); end
        tests++; if (bus.ins_pc !== 16'h8000) begin fails++; $display("[TB] FAIL imm_ins_pc: got %h expected 8000", bus.ins_pc); end
        tests++; if (bus.pc_next !== 16'h8002 || bus.mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL imm_pc_next: got %h rd %b expected 8002 0", bus.pc_next, bus.mem_rd); end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
        tests++; if (bus.ins_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8002) begin
            fails++; $display("[TB] FAIL imm_after_hs: got valid %b rd %b addr %h expected 0 1 8002", bus.ins_valid, bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        mem[16'h8000] = 8'h6C; mem[16'h8001] = 8'hFE; mem[16'h8002] = 8'h12; mem[16'h8003] = 8'hEA;
        load_pc(16'h8000);
        tick(); tick(); tick();
        tests++; if (bus.ins_valid !== 1'b1 || bus.ins_mode !== Ind) begin fails++; $display("[TB] FAIL ind_mode: got valid %b mode %0d expected 1 %0d", bus.ins_valid, bus.ins_mode, Ind); end
        tests++; if (bus.ins_operand !== 16'h12FE) begin fails++; $display("[TB] FAIL ind_operand: got %h expected 12FE", bus.ins_operand); end
        tests++; if (bus.ins_len !== 2'd3 || bus.pc_next !== 16'h8003) begin fails++; $display("[TB] FAIL ind_len_pc: got %0d %h expected 3 8003", bus.ins_len, bus.pc_next); end
        bus.ins_ready = 1'b1;
        tick();
        tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h8003) begin fails++; $display("[TB] FAIL b2b_fetch: got rd %b addr %h expected 1 8003", bus.mem_rd, bus.mem_addr); end
        tick();
        tests++; if (bus.ins_valid !== 1'b1 || bus.ins_opcode !== 8'hEA || bus.ins_len !== 2'd1) begin
            fails++; $display("[TB] FAIL b2b_nop: got valid %b op %h len %0d expected 1 EA 1", bus.ins_valid, bus.ins_opcode, bus.ins_len);
        end
        tests++; if (bus.ins_operand !== 16'h0000 || bus.ins_pc !== 16'h8003 || bus.ins_mode !== Imp) begin
            fails++; $display("[TB] FAIL b2b_fields: got operand %h pc %h mode %0d expected 0000 8003 %0d", bus.ins_operand, bus.ins_pc, bus.ins_mode, Imp);
        end
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic test_stall();
        mem[16'h9000] = 8'hAD; mem[16'h9001] = 8'h34; mem[16'h9002] = 8'h12;
        load_pc(16'h9000);
        tick();
        bus.mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (bus.mem_addr !== 16'h9001 || bus.pc_next !== 16'h9001 || bus.ins_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL stall_lo%0d: got addr %h valid %b expected 9001 0", i, bus.mem_addr, bus.ins_valid);
            end
        end
        bus.mem_rdy = 1'b1;
        tick();
        tests++; if (bus.mem_addr !== 16'h9002) begin fails++; $display("[TB] FAIL stall_hi: got %h expected 9002", bus.mem_addr); end
        tick();
        tests++; if (bus.ins_valid !== 1'b1 || bus.ins_operand !== 16'h1234 || bus.ins_mode !== Abs) begin
            fails++; $display("[TB] FAIL stall_ins: got valid %b operand %h mode %0d expected 1 1234 %0d", bus.ins_valid, bus.ins_operand, bus.ins_mode, Abs);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (bus.ins_valid !== 1'b1 || bus.ins_opcode !== 8'hAD || bus.ins_operand !== 16'h1234 || bus.ins_len !== 2'd3
                         || bus.ins_pc !== 16'h9000 || bus.ins_mode !== Abs || bus.mem_rd !== 1'b0 || bus.pc_next !== 16'h9003) begin
                fails++; $display("[TB] FAIL hold%0d: got valid %b op %h operand %h pc %h rd %b next %h expected 1 AD 1234 9000 0 9003",
                                  i, bus.ins_valid, bus.ins_opcode, bus.ins_operand, bus.ins_pc, bus.mem_rd, bus.pc_next);
            end
        end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic test_flush();
        mem[16'hA000] = 8'hAD; mem[16'hA001] = 8'h11; mem[16'hA002] = 8'h22;
        mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h07;
        load_pc(16'hA000);
        tick();
        load_pc(16'hC000);
        tests++; if (bus.mem_addr !== 16'hC000 || bus.mem_rd !== 1'b1 || bus.ins_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL flush_redirect: got addr %h rd %b valid %b expected C000 1 0", bus.mem_addr, bus.mem_rd, bus.ins_valid);
        end
        tick();
        tests++; if (bus.ins_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_no_valid: got %b expected 0", bus.ins_valid); end
        tick();
        tests++; if (bus.ins_valid !== 1'b1 || bus.ins_opcode !== 8'hA2 || bus.ins_operand !== 16'h0007 || bus.ins_pc !== 16'hC000) begin
            fails++; $display("[TB] FAIL flush_ins: got valid %b op %h operand %h pc %h expected 1 A2 0007 C000", bus.ins_valid, bus.ins_opcode, bus.ins_operand, bus.ins_pc);
        end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 8'h20; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        load_pc(16'hFFFF);
        tests++; if (bus.mem_addr !== 16'hFFFF) begin fails++; $display("[TB] FAIL wrap_a0: got %h expected FFFF", bus.mem_addr); end
        tick();
        tests++; if (bus.mem_addr !== 16'h0000) begin fails++; $display("[TB] FAIL wrap_a1: got %h expected 0000", bus.mem_addr); end
        tick();
        tests++; if (bus.mem_addr !== 16'h0001) begin fails++; $display("[TB] FAIL wrap_a2: got %h expected 0001", bus.mem_addr); end
        tick();
        tests++; if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 16'hFFFF || bus.ins_len !== 2'd3 || bus.ins_operand !== 16'h1234 || bus.pc_next !== 16'h0002) begin
            fails++; $display("[TB] FAIL wrap_ins: got valid %b pc %h len %0d operand %h next %h expected 1 FFFF 3 1234 0002",
                              bus.ins_valid, bus.ins_pc, bus.ins_len, bus.ins_operand, bus.pc_next);
        end
        bus.ins_ready = 1'b1;
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem[16'h9000] = 8'hAD;
        load_pc(16'h9000);
        tick();
        reset = 1'b1;
        tick();
        tests++; if (bus.ins_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.pc_next !== 16'h0000 || bus.ins_opcode !== 8'h00 || bus.ins_pc !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_mid: got valid %b rd %b pc %h op %h ins_pc %h expected 0 0 0000 00 0000",
                              bus.ins_valid, bus.mem_rd, bus.pc_next, bus.ins_opcode, bus.ins_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_mode_sweep();
        logic [7:0]  ops   [10];
        addressing_t modes [10];
        logic [1:0]  lens  [10];
        logic [15:0] base;
        logic [15:0] exp_operand;
        ops   = '{8'h96, 8'hBE, 8'h97, 8'h9F, 8'h02, 8'h80, 8'h10, 8'h00, 8'hB1, 8'h4C};
        modes = '{ZpY, AbY, ZpY, AbY, Imp, Imm, Rel, Imp, IzY, Abs};
        lens  = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 10; i++) begin
            base = 16'h4000 + 16'(i * 4);
            mem[base] = ops[i]; mem[base + 16'd1] = 8'h5A; mem[base + 16'd2] = 8'hA5;
            exp_operand = (lens[i] == 2'd1) ? 16'h0000 : (lens[i] == 2'd2) ? 16'h005A : 16'hA55A;
            load_pc(base);
            for (int k = 0; k < 6 && bus.ins_valid !== 1'b1; k++) tick();
            tests++; if (bus.ins_valid !== 1'b1) begin
                fails++; $display("[TB] FAIL sweep_timeout_%h: got valid %b expected 1", ops[i], bus.ins_valid);
            end else begin
                tests++; if (bus.ins_mode !== modes[i] || bus.ins_len !== lens[i] || bus.ins_operand !== exp_operand) begin
                    fails++; $display("[TB] FAIL sweep_%h: got mode %0d len %0d operand %h expected %0d %0d %h",
                                      ops[i], bus.ins_mode, bus.ins_len, bus.ins_operand, modes[i], lens[i], exp_operand);
                end
            end
            bus.ins_ready = 1'b1;
            tick();
            bus.ins_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_mode_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
